// File: rtl/apb_cmd_master_pkg.sv
// Shared types and default sizes for the command-to-APB bridge.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned APB_ADDR_W  = 8;
    localparam int unsigned APB_DATA_W  = 8;
    localparam int unsigned APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signals of the bridge, seen from the bridge (master)
// and from its environment (slave).
interface apb_cmd_master_if
    import apb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master_wait_timer.sv
// ACCESS wait-state counter; expired_o flags the edge on which the count
// reaches TIMEOUT, so the caller can abort on that same edge.
module apb_wait_timer
    import apb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = APB_TIMEOUT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam bit               TO_EN  = (TIMEOUT != 32'd0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = TO_EN && en_i && !clr_i && (cnt_d == TO_CNT);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS (wait/timeout) -> RESP.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = APB_TIMEOUT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_cmd_master_if.master  bus
);
    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (tmr_expired_s)
    );

    // next state and transfer fields; bus outputs are decoded from the next state
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d   = SETUP;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_wdata;
                    tmr_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY has priority over a timeout reached on the same edge
                if (bus.PREADY) begin
                    state_d     = RESP;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : bus.PRDATA;
                    rsp_err_d   = 1'b0;
                end else begin
                    tmr_en_s = 1'b1;
                    if (tmr_expired_s) begin
                        state_d     = RESP;
                        rsp_rdata_d = {DATA_W{1'b0}};
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    // state and output registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwdata_q    <= {DATA_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a TIMEOUT=4 instance against a transfer-level model,
// and a TIMEOUT=0 instance exercised with random PREADY back-to-back traffic.
module tb_apb_cmd_master;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int TO_A = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 PCLK = ~PCLK;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_A), .CNT_W(5)) u_dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (ifa.master)
    );

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0), .CNT_W(5)) u_dut_nt (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (ifb.master)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // 4-register APB peripherals behind each bridge
    logic [7:0] mem_a [4];
    logic [7:0] mem_b [4];
    assign ifa.PRDATA = mem_a[ifa.PADDR[1:0]];
    assign ifb.PRDATA = mem_b[ifb.PADDR[1:0]];

    always @(posedge PCLK) begin
        if (ifa.PSEL && ifa.PENABLE && ifa.PREADY && ifa.PWRITE) mem_a[ifa.PADDR[1:0]] <= ifa.PWDATA;
        if (ifb.PSEL && ifb.PENABLE && ifb.PREADY && ifb.PWRITE) mem_b[ifb.PADDR[1:0]] <= ifb.PWDATA;
    end

    // Transfer-level model of instance A: phase 0 idle, 1 setup, 2 access, 3 response
    bit         m_on    = 1'b0;
    bit         m_fresh = 1'b1;
    int         m_ph    = 0;
    int         m_wait  = 0;
    logic       m_pw    = 1'b0;
    logic [7:0] m_pa    = 8'h00;
    logic [7:0] m_pd    = 8'h00;
    logic [7:0] m_rd    = 8'h00;
    logic       m_err   = 1'b0;
    logic [7:0] m_mem [4];

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_on <= 1'b1; m_fresh <= 1'b1; m_ph <= 0;
            m_pw <= 1'b0; m_pa <= 8'h00; m_pd <= 8'h00; m_rd <= 8'h00; m_err <= 1'b0;
        end else begin
            m_fresh <= 1'b0;
            case (m_ph)
                0: if (ifa.cmd_valid && !m_fresh) begin
                    m_ph <= 1; m_pw <= ifa.cmd_write; m_pa <= ifa.cmd_addr; m_pd <= ifa.cmd_wdata;
                end
                1: begin m_ph <= 2; m_wait <= 0; end
                2: if (ifa.PREADY) begin
                    m_ph <= 3; m_err <= 1'b0;
                    if (m_pw) begin m_rd <= 8'h00; m_mem[m_pa[1:0]] <= m_pd; end
                    else m_rd <= m_mem[m_pa[1:0]];
                end else if (m_wait + 1 == TO_A) begin
                    m_ph <= 3; m_err <= 1'b1; m_rd <= 8'h00;
                end else begin
                    m_wait <= m_wait + 1;
                end
                3: if (ifa.rsp_ready) m_ph <= 0;
                default: m_ph <= 0;
            endcase
        end
    end

    // per-cycle comparison of instance A against the model
    always @(negedge PCLK) begin
        if (m_on) begin
            chk("a_psel",      ifa.PSEL,      (m_ph == 1) || (m_ph == 2));
            chk("a_penable",   ifa.PENABLE,   (m_ph == 2));
            chk("a_rsp_valid", ifa.rsp_valid, (m_ph == 3));
            chk("a_cmd_ready", ifa.cmd_ready, (m_ph == 0) && !m_fresh);
            chk("a_pwrite",    ifa.PWRITE,    m_pw);
            chk("a_paddr",     ifa.PADDR,     m_pa);
            chk("a_pwdata",    ifa.PWDATA,    m_pd);
            chk("a_rsp_rdata", ifa.rsp_rdata, m_rd);
            chk("a_rsp_err",   ifa.rsp_err,   m_err);
        end
    end

    // APB protocol properties on instance B
    bit         b_in   = 1'b0;
    logic [7:0] b_addr = 8'h00;
    logic [7:0] b_data = 8'h00;
    always @(negedge PCLK) begin
        if (m_on) begin
            chk("b_penable_implies_psel", ifb.PENABLE && !ifb.PSEL, 1'b0);
            if (ifb.PSEL && !b_in) begin
                b_in <= 1'b1; b_addr <= ifb.PADDR; b_data <= ifb.PWDATA;
            end else if (ifb.PSEL) begin
                chk("b_paddr_stable",  ifb.PADDR,  b_addr);
                chk("b_pwdata_stable", ifb.PWDATA, b_data);
            end else begin
                b_in <= 1'b0;
            end
        end
    end

    // issue one command on A; returns at the first response cycle
    task automatic xfer_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input int bp,
                          output logic [7:0] rd, output logic er, output int acc, output int lat);
        int n;
        n = 0;
        while (!ifa.cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        chk("a_cmd_ready_wait", ifa.cmd_ready, 1'b1);
        ifa.cmd_valid = 1'b1; ifa.cmd_write = w; ifa.cmd_addr = a; ifa.cmd_wdata = d;
        ifa.PREADY = 1'b0; ifa.rsp_ready = (bp == 0);
        @(negedge PCLK);
        ifa.cmd_valid = 1'b0;
        lat = 1; acc = 0;
        while (!ifa.rsp_valid && lat < 200) begin
            if (ifa.PENABLE) begin acc++; ifa.PREADY = (acc > waits); end
            @(negedge PCLK);
            lat++;
        end
        chk("a_rsp_seen", ifa.rsp_valid, 1'b1);
        ifa.PREADY = 1'b0;
        rd = ifa.rsp_rdata; er = ifa.rsp_err;
    endtask

    task automatic finish_rsp_a();
        ifa.rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("a_rsp_done", ifa.rsp_valid, 1'b0);
        chk("a_idle_ready", ifa.cmd_ready, 1'b1);
    endtask

    logic [7:0] rd;
    logic       er;
    int         acc, lat;
    logic [7:0] tbl [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        tbl[0] = 8'hAA; tbl[1] = 8'hBB; tbl[2] = 8'hCC; tbl[3] = 8'hDD;
        ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_addr = 8'h00; ifa.cmd_wdata = 8'h00;
        ifa.rsp_ready = 1'b1; ifa.PREADY = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_addr = 8'h00; ifb.cmd_wdata = 8'h00;
        ifb.rsp_ready = 1'b1; ifb.PREADY = 1'b0;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("rst_psel",      ifa.PSEL,      1'b0);
        chk("rst_penable",   ifa.PENABLE,   1'b0);
        chk("rst_rsp_valid", ifa.rsp_valid, 1'b0);
        chk("rst_cmd_ready", ifa.cmd_ready, 1'b0);
        chk("rst_paddr",     ifa.PADDR,     8'h00);
        chk("rst_pwdata",    ifa.PWDATA,    8'h00);
        chk("rst_rsp_rdata", ifa.rsp_rdata, 8'h00);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rel_cmd_ready", ifa.cmd_ready, 1'b1);

        // zero-wait write
        xfer_a(1'b1, 8'h00, 8'hAA, 0, 0, rd, er, acc, lat);
        chk("w0_latency", lat, 3); chk("w0_access", acc, 1);
        chk("w0_rdata", rd, 8'h00); chk("w0_err", er, 1'b0);
        finish_rsp_a();

        // write 0xDD to 3, then read it back with 3 wait states
        xfer_a(1'b1, 8'h03, 8'hDD, 0, 0, rd, er, acc, lat);
        finish_rsp_a();
        xfer_a(1'b0, 8'h03, 8'h00, 3, 0, rd, er, acc, lat);
        chk("r3w_access", acc, 4); chk("r3w_latency", lat, 6);
        chk("r3w_rdata", rd, 8'hDD); chk("r3w_err", er, 1'b0);
        finish_rsp_a();

        // timeout with PREADY held low
        xfer_a(1'b0, 8'h03, 8'h00, 1000, 0, rd, er, acc, lat);
        chk("to_access", acc, 4); chk("to_err", er, 1'b1); chk("to_rdata", rd, 8'h00);
        chk("to_psel", ifa.PSEL, 1'b0); chk("to_penable", ifa.PENABLE, 1'b0);
        finish_rsp_a();

        // response backpressure on a read of 0xBB
        xfer_a(1'b1, 8'h01, 8'hBB, 0, 0, rd, er, acc, lat);
        finish_rsp_a();
        xfer_a(1'b0, 8'h01, 8'h00, 0, 5, rd, er, acc, lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", ifa.rsp_valid, 1'b1);
            chk("bp_rdata",     ifa.rsp_rdata, 8'hBB);
            chk("bp_cmd_ready", ifa.cmd_ready, 1'b0);
            chk("bp_psel",      ifa.PSEL,      1'b0);
            if (k < 4) @(negedge PCLK);
        end
        finish_rsp_a();

        // reset during ACCESS of a write to 0x02
        ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b1; ifa.cmd_addr = 8'h02; ifa.cmd_wdata = 8'h77;
        ifa.PREADY = 1'b0;
        @(negedge PCLK);
        ifa.cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("mr_in_access", ifa.PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mr_psel", ifa.PSEL, 1'b0); chk("mr_penable", ifa.PENABLE, 1'b0);
        chk("mr_rsp_valid", ifa.rsp_valid, 1'b0); chk("mr_cmd_ready", ifa.cmd_ready, 1'b0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("mr_rel_cmd_ready", ifa.cmd_ready, 1'b1);
        repeat (3) begin
            chk("mr_no_rsp", ifa.rsp_valid, 1'b0);
            @(negedge PCLK);
        end

        // instance B: 4 writes then 4 reads, random PREADY, no timeout
        for (int i = 0; i < 8; i++) begin
            int n;
            n = 0;
            while (!ifb.cmd_ready && n < 20) begin @(negedge PCLK); n++; end
            chk("b_cmd_ready_wait", ifb.cmd_ready, 1'b1);
            ifb.cmd_valid = 1'b1;
            ifb.cmd_write = (i < 4);
            ifb.cmd_addr  = 8'(i % 4);
            ifb.cmd_wdata = (i < 4) ? tbl[i] : 8'h00;
            @(negedge PCLK);
            ifb.cmd_valid = 1'b0;
            n = 0;
            while (!ifb.rsp_valid && n < 500) begin
                if (ifb.PENABLE) ifb.PREADY = ((i != 4) || (n >= 10)) && ($urandom_range(0, 9) < 4);
                @(negedge PCLK);
                n++;
            end
            ifb.PREADY = 1'b0;
            chk("b_rsp_seen", ifb.rsp_valid, 1'b1);
            chk("b_rsp_err",  ifb.rsp_err,   1'b0);
            chk("b_rdata",    ifb.rsp_rdata, (i < 4) ? 8'h00 : tbl[i - 4]);
            @(negedge PCLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
